// File: rtl/rob_retire.sv
// In-order commit stage on the ROB extraction side: retires the eligible head prefix,
// writes the register file, serialises stores and turns an excepting head into a flush.
package rob_retire_pkg;
   typedef struct packed {
      logic [4:0]  dest_reg;
      logic        dest_reg_valid;
      logic [31:0] result_lo;
      logic        is_store;
      logic [31:0] mem_addr;
      logic [31:0] mem_data;
      logic [3:0]  mem_be;
      logic        exception;
      logic [31:0] pc;
   } rob_entry_t;
endpackage

module rob_retire #(
   parameter type T            = rob_retire_pkg::rob_entry_t,
   parameter int  DEPTH        = 16,
   parameter int  EXT_COUNT    = 2,
   parameter int  DEPTHLOG2    = $clog2(DEPTH),
   parameter int  EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
   input  logic                             clock_i,
   input  logic                             reset_n_i,
   input  T            [EXT_COUNT-1:0]      slot_data_i,
   input  logic        [EXT_COUNT-1:0]      slot_valid_i,
   input  logic                             empty_i,
   input  logic        [DEPTHLOG2:0]        used_count_i,
   output logic                             consume_o,
   output logic        [EXTCOUNTLOG2-1:0]   consume_count_o,
   output logic        [EXT_COUNT-1:0]      rf_wr_en_o,
   output logic        [EXT_COUNT-1:0][4:0] rf_wr_reg_o,
   output logic        [EXT_COUNT-1:0][31:0] rf_wr_data_o,
   output logic                             st_req_o,
   output logic        [31:0]               st_addr_o,
   output logic        [31:0]               st_data_o,
   output logic        [3:0]                st_be_o,
   input  logic                             st_ack_i,
   output logic                             flush_o,
   output logic        [31:0]               flush_pc_o,
   output logic        [31:0]               retired_count_o
);

   localparam int KW = EXTCOUNTLOG2 + 1;

   typedef enum logic [1:0] {IDLE, ST_WAIT, FLUSH} state_e;

   state_e                     state_q, state_d;
   logic [EXT_COUNT-1:0]       rf_wr_en_q, rf_wr_en_d;
   logic [EXT_COUNT-1:0][4:0]  rf_wr_reg_q, rf_wr_reg_d;
   logic [EXT_COUNT-1:0][31:0] rf_wr_data_q, rf_wr_data_d;
   logic                       st_req_q, st_req_d;
   logic [31:0]                st_addr_q, st_addr_d;
   logic [31:0]                st_data_q, st_data_d;
   logic [3:0]                 st_be_q, st_be_d;
   logic                       flush_q, flush_d;
   logic [31:0]                flush_pc_q, flush_pc_d;
   logic [31:0]                retired_q, retired_d;
   logic [EXT_COUNT-1:0]       retire_mask;
   logic [KW-1:0]              k;
   logic                       lane0_ok;

   // Next-state, retirement selection and combinational ROB handshake.
   always_comb begin
      logic run;
      logic dup;
      state_d         = state_q;
      rf_wr_en_d      = '0;
      rf_wr_reg_d     = rf_wr_reg_q;
      rf_wr_data_d    = rf_wr_data_q;
      st_req_d        = st_req_q;
      st_addr_d       = st_addr_q;
      st_data_d       = st_data_q;
      st_be_d         = st_be_q;
      flush_d         = 1'b0;
      flush_pc_d      = flush_pc_q;
      retire_mask     = '0;
      k               = '0;
      run             = 1'b1;
      dup             = 1'b0;
      consume_o       = 1'b0;
      consume_count_o = '0;
      lane0_ok        = !empty_i && (used_count_i != '0) && slot_valid_i[0];
      case (state_q)
         IDLE: begin
            // A special lane ends the run; it is only handled further when it is lane 0.
            for (int i = 0; i < EXT_COUNT; i++) begin
               if (run && !empty_i && (i < int'(used_count_i)) && slot_valid_i[i]) begin
                  if (!slot_data_i[i].is_store && !slot_data_i[i].exception) begin
                     retire_mask[i] = 1'b1;
                     k              = k + KW'(1);
                  end else begin
                     run = 1'b0;
                  end
               end else begin
                  run = 1'b0;
               end
            end
            if (k != '0) begin
               consume_o       = 1'b1;
               consume_count_o = EXTCOUNTLOG2'(k - KW'(1));
               for (int i = 0; i < EXT_COUNT; i++) begin
                  dup = 1'b0;
                  for (int j = i + 1; j < EXT_COUNT; j++) begin
                     if (retire_mask[j] && slot_data_i[j].dest_reg_valid &&
                         (slot_data_i[j].dest_reg == slot_data_i[i].dest_reg)) begin
                        dup = 1'b1;
                     end else begin
                        dup = dup;
                     end
                  end
                  if (retire_mask[i] && slot_data_i[i].dest_reg_valid &&
                      (slot_data_i[i].dest_reg != 5'd0) && !dup) begin
                     rf_wr_en_d[i]   = 1'b1;
                     rf_wr_reg_d[i]  = slot_data_i[i].dest_reg;
                     rf_wr_data_d[i] = slot_data_i[i].result_lo;
                  end else begin
                     rf_wr_en_d[i] = 1'b0;
                  end
               end
            end else if (lane0_ok && slot_data_i[0].is_store) begin
               st_req_d  = 1'b1;
               st_addr_d = slot_data_i[0].mem_addr;
               st_data_d = slot_data_i[0].mem_data;
               st_be_d   = slot_data_i[0].mem_be;
               state_d   = ST_WAIT;
            end else if (lane0_ok && slot_data_i[0].exception) begin
               consume_o  = 1'b1;
               flush_d    = 1'b1;
               flush_pc_d = slot_data_i[0].pc;
               state_d    = FLUSH;
            end else begin
               state_d = IDLE;
            end
         end
         ST_WAIT: begin
            if (st_ack_i) begin
               consume_o = 1'b1;
               st_req_d  = 1'b0;
               state_d   = IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         FLUSH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (consume_o) begin
         retired_d = retired_q + 32'(consume_count_o) + 32'd1;
      end else begin
         retired_d = retired_q;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= IDLE;
         rf_wr_en_q   <= '0;
         rf_wr_reg_q  <= '0;
         rf_wr_data_q <= '0;
         st_req_q     <= 1'b0;
         st_addr_q    <= 32'd0;
         st_data_q    <= 32'd0;
         st_be_q      <= 4'd0;
         flush_q      <= 1'b0;
         flush_pc_q   <= 32'd0;
         retired_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         rf_wr_en_q   <= rf_wr_en_d;
         rf_wr_reg_q  <= rf_wr_reg_d;
         rf_wr_data_q <= rf_wr_data_d;
         st_req_q     <= st_req_d;
         st_addr_q    <= st_addr_d;
         st_data_q    <= st_data_d;
         st_be_q      <= st_be_d;
         flush_q      <= flush_d;
         flush_pc_q   <= flush_pc_d;
         retired_q    <= retired_d;
      end
   end

   assign rf_wr_en_o      = rf_wr_en_q;
   assign rf_wr_reg_o     = rf_wr_reg_q;
   assign rf_wr_data_o    = rf_wr_data_q;
   assign st_req_o        = st_req_q;
   assign st_addr_o       = st_addr_q;
   assign st_data_o       = st_data_q;
   assign st_be_o         = st_be_q;
   assign flush_o         = flush_q;
   assign flush_pc_o      = flush_pc_q;
   assign retired_count_o = retired_q;

endmodule

// File: tb/tb_rob_retire.sv
// Directed self-checking bench for rob_retire with hand-computed expectations.
module tb_rob_retire;
   import rob_retire_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   rob_entry_t [1:0] slot_data;
   logic [1:0]       slot_valid;
   logic             empty;
   logic [4:0]       used_count;
   logic             consume;
   logic [0:0]       consume_count;
   logic [1:0]       rf_wr_en;
   logic [1:0][4:0]  rf_wr_reg;
   logic [1:0][31:0] rf_wr_data;
   logic             st_req;
   logic [31:0]      st_addr, st_data;
   logic [3:0]       st_be;
   logic             st_ack;
   logic             flush;
   logic [31:0]      flush_pc;
   logic [31:0]      retired_count;
   int               n_checks = 0;
   int               n_fail = 0;

   always #5 clk = ~clk;

   rob_retire dut (
      .clock_i(clk), .reset_n_i(rst_n), .slot_data_i(slot_data), .slot_valid_i(slot_valid),
      .empty_i(empty), .used_count_i(used_count), .consume_o(consume),
      .consume_count_o(consume_count), .rf_wr_en_o(rf_wr_en), .rf_wr_reg_o(rf_wr_reg),
      .rf_wr_data_o(rf_wr_data), .st_req_o(st_req), .st_addr_o(st_addr), .st_data_o(st_data),
      .st_be_o(st_be), .st_ack_i(st_ack), .flush_o(flush), .flush_pc_o(flush_pc),
      .retired_count_o(retired_count)
   );

   function automatic rob_entry_t mk_alu(logic [4:0] d, logic dv, logic [31:0] r);
      rob_entry_t e;
      e = '0; e.dest_reg = d; e.dest_reg_valid = dv; e.result_lo = r;
      return e;
   endfunction

   function automatic rob_entry_t mk_store(logic [31:0] a, logic [31:0] d, logic [3:0] be);
      rob_entry_t e;
      e = '0; e.is_store = 1'b1; e.mem_addr = a; e.mem_data = d; e.mem_be = be;
      e.dest_reg = 5'd12; e.dest_reg_valid = 1'b1;
      return e;
   endfunction

   function automatic rob_entry_t mk_exc(logic [31:0] pc);
      rob_entry_t e;
      e = '0; e.exception = 1'b1; e.pc = pc; e.dest_reg = 5'd13; e.dest_reg_valid = 1'b1;
      return e;
   endfunction

   task automatic drive(rob_entry_t e0, rob_entry_t e1, logic [1:0] v, logic [4:0] used, logic emp);
      slot_data[0] = e0; slot_data[1] = e1; slot_valid = v; used_count = used; empty = emp;
   endtask

   task automatic idle();
      slot_data = '0; slot_valid = 2'b00; used_count = 5'd0; empty = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; st_ack = 1'b0; idle();
      #12;
      n_checks++; if (consume !== 1'b0) begin n_fail++; $display("FAIL reset_consume got %b exp 0", consume); end
      n_checks++; if (rf_wr_en !== 2'b00) begin n_fail++; $display("FAIL reset_rf_wr_en got %b exp 00", rf_wr_en); end
      n_checks++; if (st_req !== 1'b0 || st_addr !== 32'd0 || st_be !== 4'd0) begin n_fail++; $display("FAIL reset_store got %b %h %h exp 0", st_req, st_addr, st_be); end
      n_checks++; if (flush !== 1'b0 || flush_pc !== 32'd0) begin n_fail++; $display("FAIL reset_flush got %b %h exp 0", flush, flush_pc); end
      n_checks++; if (retired_count !== 32'd0) begin n_fail++; $display("FAIL reset_retired got %0d exp 0", retired_count); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_two_plain();
      @(negedge clk);
      drive(mk_alu(5'd5, 1'b1, 32'h1111_0005), mk_alu(5'd6, 1'b1, 32'h2222_0006), 2'b11, 5'd2, 1'b0);
      #1;
      n_checks++; if (consume !== 1'b1 || consume_count !== 1'b1) begin n_fail++; $display("FAIL two_plain_consume got %b/%b exp 1/1", consume, consume_count); end
      @(negedge clk); idle();
      n_checks++; if (rf_wr_en !== 2'b11) begin n_fail++; $display("FAIL two_plain_en got %b exp 11", rf_wr_en); end
      n_checks++; if (rf_wr_reg[0] !== 5'd5 || rf_wr_reg[1] !== 5'd6) begin n_fail++; $display("FAIL two_plain_reg got %0d,%0d exp 5,6", rf_wr_reg[0], rf_wr_reg[1]); end
      n_checks++; if (rf_wr_data[0] !== 32'h1111_0005 || rf_wr_data[1] !== 32'h2222_0006) begin n_fail++; $display("FAIL two_plain_data got %h,%h exp 11110005,22220006", rf_wr_data[0], rf_wr_data[1]); end
      n_checks++; if (retired_count !== 32'd2) begin n_fail++; $display("FAIL two_plain_retired got %0d exp 2", retired_count); end
   endtask

   task automatic test_partial();
      @(negedge clk);
      drive(mk_alu(5'd3, 1'b1, 32'h0000_00A3), mk_alu(5'd9, 1'b1, 32'h0000_00B9), 2'b01, 5'd2, 1'b0);
      #1;
      n_checks++; if (consume !== 1'b1 || consume_count !== 1'b0) begin n_fail++; $display("FAIL partial_consume got %b/%b exp 1/0", consume, consume_count); end
      @(negedge clk);
      drive(mk_alu(5'd4, 1'b1, 32'h0000_00C4), mk_alu(5'd0, 1'b1, 32'h0000_00D0), 2'b11, 5'd2, 1'b0);
      n_checks++; if (rf_wr_en !== 2'b01 || rf_wr_reg[0] !== 5'd3 || rf_wr_data[0] !== 32'h0000_00A3) begin n_fail++; $display("FAIL partial_rf got %b r%0d %h exp 01 r3 a3", rf_wr_en, rf_wr_reg[0], rf_wr_data[0]); end
      n_checks++; if (retired_count !== 32'd3) begin n_fail++; $display("FAIL partial_retired got %0d exp 3", retired_count); end
      #1;
      n_checks++; if (consume !== 1'b1 || consume_count !== 1'b1) begin n_fail++; $display("FAIL r0_consume got %b/%b exp 1/1", consume, consume_count); end
      @(negedge clk); idle();
      n_checks++; if (rf_wr_en !== 2'b01 || rf_wr_reg[0] !== 5'd4) begin n_fail++; $display("FAIL r0_rf got %b r%0d exp 01 r4", rf_wr_en, rf_wr_reg[0]); end
      n_checks++; if (retired_count !== 32'd5) begin n_fail++; $display("FAIL r0_retired got %0d exp 5", retired_count); end
   endtask

   task automatic test_same_reg();
      @(negedge clk);
      drive(mk_alu(5'd7, 1'b1, 32'h0000_0070), mk_alu(5'd7, 1'b1, 32'h0000_0071), 2'b11, 5'd2, 1'b0);
      #1;
      n_checks++; if (consume !== 1'b1 || consume_count !== 1'b1) begin n_fail++; $display("FAIL same_reg_consume got %b/%b exp 1/1", consume, consume_count); end
      @(negedge clk); idle();
      n_checks++; if (rf_wr_en !== 2'b10 || rf_wr_reg[1] !== 5'd7 || rf_wr_data[1] !== 32'h0000_0071) begin n_fail++; $display("FAIL same_reg_rf got %b r%0d %h exp 10 r7 71", rf_wr_en, rf_wr_reg[1], rf_wr_data[1]); end
      n_checks++; if (retired_count !== 32'd7) begin n_fail++; $display("FAIL same_reg_retired got %0d exp 7", retired_count); end
   endtask

   task automatic test_empty_stale();
      @(negedge clk);
      drive(mk_alu(5'd1, 1'b1, 32'h1), mk_alu(5'd2, 1'b1, 32'h2), 2'b11, 5'd2, 1'b1);
      #1;
      n_checks++; if (consume !== 1'b0) begin n_fail++; $display("FAIL empty_consume got %b exp 0", consume); end
      @(negedge clk);
      drive(mk_alu(5'd1, 1'b1, 32'h1), mk_alu(5'd2, 1'b1, 32'h2), 2'b11, 5'd0, 1'b0);
      #1;
      n_checks++; if (consume !== 1'b0) begin n_fail++; $display("FAIL used0_consume got %b exp 0", consume); end
      @(negedge clk); idle(); st_ack = 1'b1;
      n_checks++; if (rf_wr_en !== 2'b00 || retired_count !== 32'd7) begin n_fail++; $display("FAIL stale_state got %b %0d exp 00 7", rf_wr_en, retired_count); end
      @(negedge clk); st_ack = 1'b0;
      n_checks++; if (st_req !== 1'b0 || consume !== 1'b0 || retired_count !== 32'd7) begin n_fail++; $display("FAIL idle_ack got %b %b %0d exp 0 0 7", st_req, consume, retired_count); end
   endtask

   task automatic test_store();
      @(negedge clk);
      drive(mk_store(32'h0000_1000, 32'hDEAD_BEEF, 4'hF), mk_alu(5'd2, 1'b1, 32'h2), 2'b11, 5'd2, 1'b0);
      #1;
      n_checks++; if (consume !== 1'b0) begin n_fail++; $display("FAIL store_detect_consume got %b exp 0", consume); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         n_checks++; if (st_req !== 1'b1 || st_addr !== 32'h0000_1000 || st_data !== 32'hDEAD_BEEF || st_be !== 4'hF) begin n_fail++; $display("FAIL store_wait%0d got %b %h %h %h exp 1 1000 deadbeef f", c, st_req, st_addr, st_data, st_be); end
         n_checks++; if (consume !== 1'b0 || rf_wr_en !== 2'b00) begin n_fail++; $display("FAIL store_wait_consume%0d got %b %b exp 0 00", c, consume, rf_wr_en); end
      end
      @(negedge clk); st_ack = 1'b1; #1;
      n_checks++; if (st_req !== 1'b1 || st_addr !== 32'h0000_1000 || consume !== 1'b1 || consume_count !== 1'b0) begin n_fail++; $display("FAIL store_ack got req %b addr %h cons %b/%b exp 1 1000 1/0", st_req, st_addr, consume, consume_count); end
      @(negedge clk); st_ack = 1'b0; idle();
      n_checks++; if (st_req !== 1'b0 || rf_wr_en !== 2'b00 || retired_count !== 32'd8) begin n_fail++; $display("FAIL store_done got %b %b %0d exp 0 00 8", st_req, rf_wr_en, retired_count); end
   endtask

   task automatic test_exception();
      @(negedge clk);
      drive(mk_alu(5'd8, 1'b1, 32'h0000_0080), mk_exc(32'h0000_0400), 2'b11, 5'd2, 1'b0);
      #1;
      n_checks++; if (consume !== 1'b1 || consume_count !== 1'b0) begin n_fail++; $display("FAIL exc_c1 got %b/%b exp 1/0", consume, consume_count); end
      @(negedge clk);
      drive(mk_exc(32'h0000_0400), mk_alu(5'd9, 1'b1, 32'h9), 2'b01, 5'd1, 1'b0);
      n_checks++; if (rf_wr_en !== 2'b01 || rf_wr_reg[0] !== 5'd8 || retired_count !== 32'd9) begin n_fail++; $display("FAIL exc_c1_rf got %b r%0d %0d exp 01 r8 9", rf_wr_en, rf_wr_reg[0], retired_count); end
      #1;
      n_checks++; if (consume !== 1'b1 || consume_count !== 1'b0) begin n_fail++; $display("FAIL exc_c2 got %b/%b exp 1/0", consume, consume_count); end
      @(negedge clk);
      drive(mk_alu(5'd10, 1'b1, 32'hA), mk_alu(5'd11, 1'b1, 32'hB), 2'b11, 5'd2, 1'b0);
      #1;
      n_checks++; if (flush !== 1'b1 || flush_pc !== 32'h0000_0400) begin n_fail++; $display("FAIL exc_c3_flush got %b %h exp 1 400", flush, flush_pc); end
      n_checks++; if (consume !== 1'b0 || rf_wr_en !== 2'b00 || retired_count !== 32'd10) begin n_fail++; $display("FAIL exc_c3_state got %b %b %0d exp 0 00 10", consume, rf_wr_en, retired_count); end
      @(negedge clk); idle();
      n_checks++; if (flush !== 1'b0 || retired_count !== 32'd10) begin n_fail++; $display("FAIL exc_c4 got %b %0d exp 0 10", flush, retired_count); end
   endtask

   task automatic test_reset_mid_store();
      @(negedge clk);
      drive(mk_store(32'h0000_2000, 32'h1234_5678, 4'h3), '0, 2'b01, 5'd1, 1'b0);
      @(negedge clk);
      n_checks++; if (st_req !== 1'b1) begin n_fail++; $display("FAIL mid_req got %b exp 1", st_req); end
      #2 rst_n = 1'b0; #1;
      n_checks++; if (st_req !== 1'b0 || consume !== 1'b0 || retired_count !== 32'd0 || flush !== 1'b0) begin n_fail++; $display("FAIL mid_reset got %b %b %0d %b exp 0 0 0 0", st_req, consume, retired_count, flush); end
      @(negedge clk); rst_n = 1'b1;
      drive(mk_alu(5'd9, 1'b1, 32'h0000_0099), '0, 2'b01, 5'd1, 1'b0);
      #1;
      n_checks++; if (consume !== 1'b1 || consume_count !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got %b/%b exp 1/0", consume, consume_count); end
      @(negedge clk); idle();
      n_checks++; if (rf_wr_en !== 2'b01 || rf_wr_data[0] !== 32'h0000_0099 || st_req !== 1'b0 || retired_count !== 32'd1) begin n_fail++; $display("FAIL post_reset_retire got %b %h %b %0d exp 01 99 0 1", rf_wr_en, rf_wr_data[0], st_req, retired_count); end
   endtask

   initial begin
      test_reset();
      test_two_plain();
      test_partial();
      test_same_reg();
      test_empty_stale();
      test_store();
      test_exception();
      test_reset_mid_store();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
